xconv_sample_fifo: RTL and testbench
====================================

Name: xconv_sample_fifo

Overview:
- Upstream feeder for 2-state signed consumers such as shortint-driven stages.
- Accepts a 4-state 16-bit logic stream over valid/ready, buffers it in a small FIFO, and converts each word to 2-state signed 16-bit on the way in: X/Z bits become 0.
- Keeps per-word X/Z masks and saturating statistics so benches can see which samples lost information in the 4-state to 2-state conversion.

Parameters:
- DEPTH, 4, FIFO entries; power of two, at least 2.
- CNT_W, 16, width of the statistics counters.

Ports:
- clk  input  1  clock; every register updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  upstream word valid.
- in_ready  output  1  block can accept a word.
- in_data  input  16 (logic, 4-state)  sample; may carry X/Z.
- out_valid  output  1  head entry valid.
- out_ready  input  1  downstream accepts the head.
- out_data  output  16 (shortint, signed 2-state)  converted head word.
- out_xmask  output  16  bit i = 1 if in_data[i] was X or Z at push.
- out_had_x  output  1  OR-reduction of out_xmask.
- clr_stats  input  1  synchronous clear of the statistics counters.
- cnt_total  output  CNT_W  accepted words, saturating.
- cnt_x  output  CNT_W  accepted words with any X/Z bit, saturating.
- level  output  $clog2(DEPTH)+1  current occupancy.

Behaviour:
- Reset (rst high at a rising edge): pointers, level, counters, out_valid, out_data, out_xmask and out_had_x all go to 0. in_ready is combinationally 0 while rst is high. Mid-operation reset discards all buffered entries, with no partial pop.
- Handshakes:
  - push = in_valid && in_ready.
  - pop = out_valid && out_ready.
  - in_ready = !rst && (level != DEPTH).
  - out_valid = (level != 0).
- Conversion at push, per bit: 1 maps to 1; 0, X and Z map to 0. xmask bit = 1 for X or Z. Both are stored alongside the data.
- Latency: a word pushed at edge N is visible on out_data/out_valid after edge N; there is no same-cycle fall-through.
- Output contents:
  - Non-empty: out_data, out_xmask and out_had_x are driven from the head entry.
  - Empty: they are driven to 0.
- Full (level == DEPTH): in_ready = 0, so no push occurs. A pop in that cycle drops level to DEPTH-1, and in_ready rises in the next cycle. There is no bypass-on-full.
- Empty: a pop is impossible because out_valid = 0.
- Simultaneous push and pop with 0 < level < DEPTH: level is unchanged, the head advances and the new entry is written at the tail.
- Pointers: log2(DEPTH) bits; they wrap from DEPTH-1 to 0 naturally.
- level: increments on push-only, decrements on pop-only, otherwise holds.
- Counters:
  - On push, cnt_total += 1.
  - If the pushed word has any X/Z bit, cnt_x += 1.
  - Both saturate at 2^CNT_W-1 with no wrap.
- clr_stats:
  - Asserted alone: both counters become 0 on that edge.
  - Asserted in the same cycle as a push: the clear wins and then the push counts, so cnt_total = 1 and cnt_x = 1 if the word had X/Z, else 0.
  - It does not affect FIFO contents.
- Width rules: out_data is the raw 16-bit pattern reinterpreted as signed. 16'hFFFF reads as -1 and 16'h8000 as -32768. No arithmetic is applied to the data.
- Invariants:
  - 0 ≤ level ≤ DEPTH.
  - out_had_x == |out_xmask.
  - cnt_x ≤ cnt_total.

Test Plan:
- Reset then idle: after rst is released, in_ready = 1, out_valid = 0, out_data = 0, level = 0, both counters 0. Assert rst mid-stream with 3 entries held: next cycle level = 0 and out_valid = 0.
- Push 16'h8000, 16'h7FFF, 16'hFFFF with out_ready = 1 at the consumer:
  - out_data reads -32768, 32767, -1 in order.
  - out_had_x = 0 throughout.
  - cnt_total = 3, cnt_x = 0.
- Push 16'b1x0z_1111_0000_xxxx:
  - out_data = 16'h8F00.
  - out_xmask = 16'h500F.
  - out_had_x = 1, cnt_x = 1.
- Fill with out_ready = 0 and DEPTH = 4:
  - After 4 pushes, level = 4 and in_ready = 0. A 5th valid word is held and not accepted.
  - Pulse out_ready for one cycle: level = 3, in_ready = 1 the next cycle, head order preserved.
- Stream 20 words with in_valid = 1 and out_ready = 1 continuously, including pointer wrap:
  - Output order equals input order.
  - level stays at 1 after the first word.
  - cnt_total = 20.
- CNT_W = 4:
  - 17 pushes leave cnt_total = 15 (saturated).
  - clr_stats together with an X-bearing push gives cnt_total = 1, cnt_x = 1.

Source files
------------

// File: rtl/xconv_sample_fifo.sv
// Small valid/ready FIFO that folds a 4-state 16-bit stream into 2-state signed
// words, keeping a per-word X/Z mask and saturating accept/X statistics.
module xconv_sample_fifo #(
    parameter int DEPTH = 4,
    parameter int CNT_W = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [15:0]             in_data,
    output logic                    out_valid,
    input  logic                    out_ready,
    output shortint                 out_data,
    output logic [15:0]             out_xmask,
    output logic                    out_had_x,
    input  logic                    clr_stats,
    output logic [CNT_W-1:0]        cnt_total,
    output logic [CNT_W-1:0]        cnt_x,
    output logic [$clog2(DEPTH):0]  level
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL = (AW+1)'(DEPTH);
    localparam logic [CNT_W-1:0] CMAX = '1;

    logic [15:0]      mem_data_q [DEPTH];
    logic [15:0]      mem_xm_q   [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [AW:0]      level_q, level_d;
    logic [CNT_W-1:0] tot_q, tot_d, xc_q, xc_d;
    logic [15:0]      conv_data, conv_xm;
    logic             push, pop;

    // Only a definite 1 survives; 0, X and Z all collapse to 0, and X/Z are flagged.
    always_comb begin
        conv_data = '0;
        conv_xm   = '0;
        for (int i = 0; i < 16; i++) begin
            conv_data[i] = (in_data[i] === 1'b1);
            conv_xm[i]   = (in_data[i] !== 1'b0) && (in_data[i] !== 1'b1);
        end
    end

    assign in_ready  = !rst && (level_q != FULL);
    assign out_valid = (level_q != '0);
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        tot_d    = clr_stats ? '0 : tot_q;
        xc_d     = clr_stats ? '0 : xc_q;
        if (push) wr_ptr_d = wr_ptr_q + 1'b1;
        if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
        case ({push, pop})
            2'b10:   level_d = level_q + 1'b1;
            2'b01:   level_d = level_q - 1'b1;
            default: level_d = level_q;
        endcase
        // Clear is applied first so a same-cycle push is still counted.
        if (push && tot_d != CMAX)               tot_d = tot_d + 1'b1;
        if (push && (|conv_xm) && xc_d != CMAX)  xc_d  = xc_d + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            tot_q    <= '0;
            xc_q     <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
            tot_q    <= tot_d;
            xc_q     <= xc_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_data_q[wr_ptr_q] <= conv_data;
            mem_xm_q[wr_ptr_q]   <= conv_xm;
        end
    end

    assign out_data  = out_valid ? shortint'(mem_data_q[rd_ptr_q]) : shortint'(0);
    assign out_xmask = out_valid ? mem_xm_q[rd_ptr_q] : '0;
    assign out_had_x = |out_xmask;
    assign cnt_total = tot_q;
    assign cnt_x     = xc_q;
    assign level     = level_q;
endmodule

// File: tb/tb_xconv_sample_fifo.sv
// Directed bench for xconv_sample_fifo: main instance (CNT_W=16) plus a CNT_W=4
// instance for saturation.
module tb_xconv_sample_fifo;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0, out_ready = 1'b0, clr_stats = 1'b0;
    logic [15:0] in_data = '0;
    logic        in_ready, out_valid, out_had_x;
    shortint     out_data;
    logic [15:0] out_xmask;
    logic [15:0] cnt_total, cnt_x;
    logic [2:0]  level;

    logic        s_in_valid = 1'b0, s_out_ready = 1'b0, s_clr = 1'b0;
    logic [15:0] s_in_data = '0;
    logic        s_in_ready, s_out_valid, s_out_had_x;
    shortint     s_out_data;
    logic [15:0] s_out_xmask;
    logic [3:0]  s_cnt_total, s_cnt_x;
    logic [2:0]  s_level;

    int  n_tests = 0, n_fail = 0;
    bit  four_state;
    logic probe;

    always #5 clk = ~clk;

    xconv_sample_fifo #(.DEPTH(4), .CNT_W(16)) u_dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_xmask(out_xmask), .out_had_x(out_had_x), .clr_stats(clr_stats),
        .cnt_total(cnt_total), .cnt_x(cnt_x), .level(level));

    xconv_sample_fifo #(.DEPTH(4), .CNT_W(4)) u_sat (
        .clk(clk), .rst(rst), .in_valid(s_in_valid), .in_ready(s_in_ready), .in_data(s_in_data),
        .out_valid(s_out_valid), .out_ready(s_out_ready), .out_data(s_out_data),
        .out_xmask(s_out_xmask), .out_had_x(s_out_had_x), .clr_stats(s_clr),
        .cnt_total(s_cnt_total), .cnt_x(s_cnt_x), .level(s_level));

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step();
        n_tests++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL rst_in_ready_low got %0b want 0", in_ready); end
        step();
        rst = 1'b0;
        #1;
        n_tests++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready got %0b want 1", in_ready); end
        n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got %0b want 0", out_valid); end
        n_tests++; if (out_data !== 16'sd0) begin n_fail++; $display("FAIL reset_out_data got %0d want 0", out_data); end
        n_tests++; if (level !== 3'd0) begin n_fail++; $display("FAIL reset_level got %0d want 0", level); end
        n_tests++; if (cnt_total !== 16'd0 || cnt_x !== 16'd0) begin
            n_fail++; $display("FAIL reset_counters got %0d/%0d want 0/0", cnt_total, cnt_x); end
    endtask

    task automatic test_signed_stream();
        logic [15:0] words [3];
        shortint     exp  [3];
        words[0] = 16'h8000; words[1] = 16'h7FFF; words[2] = 16'hFFFF;
        exp[0] = -16'sd32768; exp[1] = 16'sd32767; exp[2] = -16'sd1;
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1; in_data = words[i];
            step();
            n_tests++; if (out_data !== exp[i]) begin
                n_fail++; $display("FAIL signed_data[%0d] got %0d want %0d", i, out_data, exp[i]); end
            n_tests++; if (out_had_x !== 1'b0) begin
                n_fail++; $display("FAIL signed_had_x[%0d] got %0b want 0", i, out_had_x); end
        end
        in_valid = 1'b0;
        step();
        out_ready = 1'b0;
        n_tests++; if (level !== 3'd0 || out_valid !== 1'b0) begin
            n_fail++; $display("FAIL signed_drain level %0d valid %0b want 0/0", level, out_valid); end
        n_tests++; if (cnt_total !== 16'd3 || cnt_x !== 16'd0) begin
            n_fail++; $display("FAIL signed_counts got %0d/%0d want 3/0", cnt_total, cnt_x); end
    endtask

    task automatic test_xconv();
        logic [15:0] exp_xm;
        exp_xm = four_state ? 16'h500F : 16'h0000;
        out_ready = 1'b0;
        in_valid = 1'b1; in_data = 16'b1x0z_1111_0000_xxxx;
        step();
        in_valid = 1'b0;
        n_tests++; if (16'(out_data) !== 16'h8F00) begin
            n_fail++; $display("FAIL xconv_data got %h want 8f00", 16'(out_data)); end
        n_tests++; if (out_xmask !== exp_xm) begin
            n_fail++; $display("FAIL xconv_xmask got %h want %h", out_xmask, exp_xm); end
        n_tests++; if (out_had_x !== (|exp_xm)) begin
            n_fail++; $display("FAIL xconv_had_x got %0b want %0b", out_had_x, |exp_xm); end
        n_tests++; if (cnt_x !== (four_state ? 16'd1 : 16'd0) || cnt_total !== 16'd4) begin
            n_fail++; $display("FAIL xconv_counts got %0d/%0d want 4/%0d", cnt_total, cnt_x, four_state ? 1 : 0); end
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        n_tests++; if (out_xmask !== 16'h0 || out_had_x !== 1'b0 || out_valid !== 1'b0) begin
            n_fail++; $display("FAIL xconv_empty_outputs xm %h hx %0b v %0b want 0", out_xmask, out_had_x, out_valid); end
    endtask

    task automatic test_full();
        logic [15:0] w [5];
        for (int i = 0; i < 5; i++) w[i] = 16'hA001 + 16'(i);
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1; in_data = w[i];
            step();
        end
        n_tests++; if (level !== 3'd4 || in_ready !== 1'b0) begin
            n_fail++; $display("FAIL full_level level %0d rdy %0b want 4/0", level, in_ready); end
        in_data = w[4];
        step();
        n_tests++; if (level !== 3'd4 || 16'(out_data) !== w[0] || cnt_total !== 16'd8) begin
            n_fail++; $display("FAIL full_hold level %0d head %h tot %0d want 4/%h/8", level, 16'(out_data), cnt_total, w[0]); end
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        n_tests++; if (level !== 3'd3 || in_ready !== 1'b1 || 16'(out_data) !== w[1]) begin
            n_fail++; $display("FAIL full_pop level %0d rdy %0b head %h want 3/1/%h", level, in_ready, 16'(out_data), w[1]); end
        step();
        in_valid = 1'b0;
        n_tests++; if (level !== 3'd4) begin n_fail++; $display("FAIL full_refill level %0d want 4", level); end
        out_ready = 1'b1;
        for (int k = 1; k < 5; k++) begin
            n_tests++; if (16'(out_data) !== w[k]) begin
                n_fail++; $display("FAIL full_order[%0d] got %h want %h", k, 16'(out_data), w[k]); end
            step();
        end
        out_ready = 1'b0;
        n_tests++; if (level !== 3'd0) begin n_fail++; $display("FAIL full_drain level %0d want 0", level); end
    endtask

    task automatic test_back_to_back();
        clr_stats = 1'b1;
        step();
        clr_stats = 1'b0;
        n_tests++; if (cnt_total !== 16'd0 || cnt_x !== 16'd0) begin
            n_fail++; $display("FAIL clr_stats got %0d/%0d want 0/0", cnt_total, cnt_x); end
        out_ready = 1'b1;
        for (int i = 0; i < 20; i++) begin
            in_valid = 1'b1; in_data = 16'h1000 + 16'(i);
            step();
            n_tests++; if (16'(out_data) !== 16'h1000 + 16'(i) || level !== 3'd1) begin
                n_fail++; $display("FAIL b2b[%0d] data %h level %0d want %h/1", i, 16'(out_data), level, 16'h1000 + 16'(i)); end
        end
        in_valid = 1'b0;
        step();
        out_ready = 1'b0;
        n_tests++; if (cnt_total !== 16'd20 || level !== 3'd0) begin
            n_fail++; $display("FAIL b2b_total tot %0d level %0d want 20/0", cnt_total, level); end
    endtask

    task automatic test_reset_mid();
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1; in_data = 16'h0C00 + 16'(i);
            step();
        end
        in_valid = 1'b0;
        n_tests++; if (level !== 3'd3) begin n_fail++; $display("FAIL mid_fill level %0d want 3", level); end
        rst = 1'b1;
        out_ready = 1'b1;
        #1;
        n_tests++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL mid_rst_ready got %0b want 0", in_ready); end
        step();
        rst = 1'b0;
        out_ready = 1'b0;
        #1;
        n_tests++; if (level !== 3'd0 || out_valid !== 1'b0 || cnt_total !== 16'd0) begin
            n_fail++; $display("FAIL mid_rst level %0d valid %0b tot %0d want 0/0/0", level, out_valid, cnt_total); end
    endtask

    task automatic test_saturate();
        s_out_ready = 1'b1;
        for (int i = 0; i < 17; i++) begin
            s_in_valid = 1'b1; s_in_data = 16'h0100 + 16'(i);
            step();
        end
        s_in_valid = 1'b0;
        n_tests++; if (s_cnt_total !== 4'd15 || s_cnt_x !== 4'd0) begin
            n_fail++; $display("FAIL sat_total got %0d/%0d want 15/0", s_cnt_total, s_cnt_x); end
        s_clr = 1'b1; s_in_valid = 1'b1; s_in_data = 16'b1x0z_1111_0000_xxxx;
        step();
        s_clr = 1'b0; s_in_valid = 1'b0;
        n_tests++; if (s_cnt_total !== 4'd1 || s_cnt_x !== (four_state ? 4'd1 : 4'd0)) begin
            n_fail++; $display("FAIL sat_clr_push got %0d/%0d want 1/%0d", s_cnt_total, s_cnt_x, four_state ? 1 : 0); end
        s_out_ready = 1'b0;
    endtask

    initial begin
        probe = 1'bx;
        four_state = (probe === 1'bx);
        test_reset();
        test_signed_stream();
        test_xconv();
        test_full();
        test_back_to_back();
        test_reset_mid();
        test_saturate();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
